// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code sequencer: E0/F0 prefix FSM, prefix timeout, show-ahead event FIFO.
// Optional typematic-repeat filter enabled by defining PS2_TYPEMATIC_FILTER_EN.
module ps2_key_ctrl #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               ps2_byte,
  input  logic                     ps2_vld,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [7:0]               evt_code,
  output logic                     evt_ext,
  output logic                     evt_brk,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  state_t          state, next_state;
  logic [TW-1:0]   to_cnt;
  logic            is_ctrl;
  logic            emit, emit_ext, emit_brk;
  logic            accept;
  logic            push, pop;
  evt_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  always_comb begin
    is_ctrl = 1'b0;
    case (ps2_byte)
      8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ctrl = 1'b1;
      default:                                        is_ctrl = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_brk   = 1'b0;
    if (ps2_vld) begin
      if (is_ctrl) begin
        next_state = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (ps2_byte == 8'hE0)      next_state = EXT;
            else if (ps2_byte == 8'hF0) next_state = BRK;
            else                        emit = 1'b1;
          end
          EXT: begin
            if (ps2_byte == 8'hF0)      next_state = EXT_BRK;
            else if (ps2_byte != 8'hE0) begin
              emit       = 1'b1;
              emit_ext   = 1'b1;
              next_state = IDLE;
            end
          end
          BRK: begin
            next_state = IDLE;
            if (ps2_byte != 8'hE0 && ps2_byte != 8'hF0) begin
              emit     = 1'b1;
              emit_brk = 1'b1;
            end
          end
          EXT_BRK: begin
            next_state = IDLE;
            if (ps2_byte != 8'hE0 && ps2_byte != 8'hF0) begin
              emit     = 1'b1;
              emit_ext = 1'b1;
              emit_brk = 1'b1;
            end
          end
          default: next_state = IDLE;
        endcase
      end
    end else if (state != IDLE && to_cnt == TW'(TIMEOUT_CYC - 1)) begin
      // to_cnt holds (idle cycles - 1), so this is the TIMEOUT_CYC-th quiet cycle
      next_state = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          to_cnt <= '0;
    else if (ps2_vld)                 to_cnt <= '0;
    else if (to_cnt != TW'(TIMEOUT_CYC)) to_cnt <= to_cnt + 1'b1;
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       held_vld;
  logic       held_ext;
  logic [7:0] held_code;
  logic       held_match;

  assign held_match = held_vld && held_ext == emit_ext && held_code == ps2_byte;
  assign accept     = emit && (emit_brk || !held_match);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_vld  <= 1'b0;
      held_ext  <= 1'b0;
      held_code <= '0;
    end else if (emit) begin
      if (!emit_brk && !held_match) begin
        held_vld  <= 1'b1;
        held_ext  <= emit_ext;
        held_code <= ps2_byte;
      end else if (emit_brk && held_match) begin
        held_vld  <= 1'b0;
      end
    end
  end
`else
  assign accept = emit;
`endif

  assign pop  = evt_valid && evt_ready;
  assign push = accept && (count < CW'(DEPTH) || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{ext: emit_ext, brk: emit_brk, code: ps2_byte};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A dropped event outranks a same-cycle clear request
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  ovf <= 1'b0;
    else if (accept && !push) ovf <= 1'b1;
    else if (ovf_clr)         ovf <= 1'b0;
  end

  assign evt_valid = (count != '0);
  assign evt_count = count;
  assign evt_code  = mem[rd_ptr].code;
  assign evt_ext   = mem[rd_ptr].ext;
  assign evt_brk   = mem[rd_ptr].brk;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: stimulus pushes expected events, a negedge monitor checks pops.
module tb_ps2_key_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TO    = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ps2_byte = '0;
  logic       ps2_vld = 1'b0;
  logic       evt_valid;
  logic       evt_ready = 1'b1;
  logic [7:0] evt_code;
  logic       evt_ext, evt_brk;
  logic [$clog2(DEPTH):0] evt_count;
  logic       ovf;
  logic       ovf_clr = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] exp_q [$];   // {ext, brk, code}

  ps2_key_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ps2_byte(ps2_byte), .ps2_vld(ps2_vld),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_brk(evt_brk), .evt_count(evt_count),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pops happen at the following posedge, so checking here sees the head being accepted
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: got code=%0h ext=%0b brk=%0b, expected none",
                 evt_code, evt_ext, evt_brk);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({evt_ext, evt_brk, evt_code} != e) begin
          miscompares++;
          $display("FAIL event: got ext=%0b brk=%0b code=%0h, expected ext=%0b brk=%0b code=%0h",
                   evt_ext, evt_brk, evt_code, e[9], e[8], e[7:0]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    ps2_byte = b;
    ps2_vld  = 1'b1;
    @(posedge clk);
    #1 ps2_vld = 1'b0;
  endtask

  task automatic expect_evt(input logic ext, input logic brk, input logic [7:0] code);
    exp_q.push_back({ext, brk, code});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    evt_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !evt_valid) break;
      @(posedge clk);
      #1;
    end
    check("drain_left", exp_q.size(), 0);
    check("drain_valid", int'(evt_valid), 0);
  endtask

  initial begin
    #1;
    check("rst_valid", int'(evt_valid), 0);
    check("rst_count", int'(evt_count), 0);
    check("rst_code", int'(evt_code), 0);
    check("rst_ext_brk", int'({evt_ext, evt_brk}), 0);
    check("rst_ovf", int'(ovf), 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);

    // Plain make, then break; event must be visible the cycle after the strobe
    expect_evt(0, 0, 8'h1C);
    send(8'h1C);
    check("latency_valid", int'(evt_valid), 1);
    check("latency_code", int'(evt_code), 8'h1C);
    send(8'hF0);
    expect_evt(0, 1, 8'h1C);
    send(8'h1C);
    drain();

    // Extended break, and a control byte killing a prefix
    send(8'hE0); send(8'hF0);
    expect_evt(1, 1, 8'h75);
    send(8'h75);
    send(8'hE0); send(8'hFA);
    expect_evt(0, 0, 8'h74);
    send(8'h74);
    drain();

    // Prefix timeout boundary
    send(8'hE0);
    idle(TO);
    expect_evt(0, 0, 8'h6B);
    send(8'h6B);
    send(8'hE0);
    idle(TO - 1);
    expect_evt(1, 0, 8'h6B);
    send(8'h6B);
    drain();

    // Overflow: DEPTH+1 makes with consumer stalled
    evt_ready = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      if (i <= DEPTH) expect_evt(0, 0, 8'(i));
      send(8'(i));
    end
    check("full_count", int'(evt_count), DEPTH);
    check("full_ovf", int'(ovf), 1);
    check("full_head", int'(evt_code), 1);
    // Push concurrent with pop at full
    evt_ready = 1'b1;
    expect_evt(0, 0, 8'h0A);
    send(8'h0A);
    evt_ready = 1'b0;
    check("full_pushpop_count", int'(evt_count), DEPTH);
    check("full_pushpop_ovf", int'(ovf), 1);
    check("full_pushpop_head", int'(evt_code), 2);
    ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    check("ovf_clr", int'(ovf), 0);
    drain();

    // Typematic repeats
    expect_evt(0, 0, 8'h1C);
`ifndef PS2_TYPEMATIC_FILTER_EN
    expect_evt(0, 0, 8'h1C);
    expect_evt(0, 0, 8'h1C);
`endif
    expect_evt(0, 1, 8'h1C);
    expect_evt(0, 0, 8'h1C);
`ifndef PS2_TYPEMATIC_FILTER_EN
    expect_evt(0, 0, 8'h1C);
`endif
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C);
    send(8'h1C); send(8'h1C);
    drain();

    // Asynchronous reset mid-sequence
    evt_ready = 1'b0;
    send(8'h11); send(8'h12); send(8'h13);
    send(8'hE0);
    check("pre_rst_count", int'(evt_count), 3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", int'(evt_valid), 0);
    check("async_rst_count", int'(evt_count), 0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    evt_ready = 1'b1;
    expect_evt(0, 0, 8'h29);
    send(8'h29);
    check("post_rst_valid", int'(evt_valid), 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
